// File: rtl/mem_copy_dma_if.sv
// Single-cycle memory bus between the copy engine and a RAM.
// Read data is combinational from addr; writes land on the clock edge.
interface mem_copy_dma_if #(
    parameter int DWIDTH = 32
);
    logic              mem_en;
    logic              mem_wr;
    logic [31:0]       addr;
    logic [DWIDTH-1:0] data_wr;
    logic [DWIDTH-1:0] data_rd;

    modport master (
        output mem_en,
        output mem_wr,
        output addr,
        output data_wr,
        input  data_rd
    );

    modport slave (
        input  mem_en,
        input  mem_wr,
        input  addr,
        input  data_wr,
        output data_rd
    );
endinterface

// File: rtl/mem_copy_dma.sv
// Word-copy DMA: strict read-then-write of len words from src to dst.
// All outputs are registers updated alongside the state transition.
module mem_copy_dma #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       dst_addr,
    input  logic [AWIDTH:0]   len,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH:0]   count,
    mem_copy_dma_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    state_t            state;
    logic [31:0]       src_ptr;
    logic [31:0]       dst_ptr;
    logic [AWIDTH:0]   remaining;

    // data_wr doubles as the read buffer: loaded at the end of READ.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            src_ptr     <= '0;
            dst_ptr     <= '0;
            remaining   <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bus.mem_en  <= 1'b0;
            bus.mem_wr  <= 1'b0;
            bus.addr    <= '0;
            bus.data_wr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        count <= '0;
                        if (len != '0) begin
                            src_ptr    <= src_addr;
                            dst_ptr    <= dst_addr;
                            remaining  <= len;
                            busy       <= 1'b1;
                            bus.mem_en <= 1'b1;
                            bus.mem_wr <= 1'b0;
                            bus.addr   <= src_addr;
                            state      <= READ;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        busy       <= 1'b0;
                        bus.mem_en <= 1'b0;
                        bus.addr   <= '0;
                        state      <= IDLE;
                    end else begin
                        bus.data_wr <= bus.data_rd;
                        bus.mem_wr  <= 1'b1;
                        bus.addr    <= dst_ptr;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    src_ptr     <= src_ptr + 32'd1;
                    dst_ptr     <= dst_ptr + 32'd1;
                    remaining   <= remaining - 1'b1;
                    count       <= count + 1'b1;
                    bus.mem_wr  <= 1'b0;
                    bus.data_wr <= '0;
                    if (abort || remaining == (AWIDTH+1)'(1)) begin
                        busy       <= 1'b0;
                        bus.mem_en <= 1'b0;
                        bus.addr   <= '0;
                        done       <= !abort;
                        state      <= abort ? IDLE : DONE;
                    end else begin
                        bus.addr <= src_ptr + 32'd1;
                        state    <= READ;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: table of directed transfers, random transfers,
// reset and busy-start corner cases, all against a forward-copy model.
module tb_mem_copy_dma;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int N  = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   src_addr = '0;
    logic [31:0]   dst_addr = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic [AW:0]   count;

    mem_copy_dma_if #(.DWIDTH(DW)) bus ();

    mem_copy_dma #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .start    (start),
        .abort    (abort),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram  [N];
    logic [DW-1:0] mram [N];

    assign bus.data_rd = ram[bus.addr[AW-1:0]];

    always @(posedge clk)
        if (bus.mem_en && bus.mem_wr)
            ram[bus.addr[AW-1:0]] <= bus.data_wr;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          n;
        int          ab;
        bit          noise;
        int          tail;
        int          cnt;
        int          dn;
        string       tag;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [79:0] got,
                       input logic [79:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic chk_ram(input string tag);
        int bad = 0;
        int first = -1;
        for (int i = 0; i < N; i++)
            if (ram[i] !== mram[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        vecs++;
        if (bad != 0) begin
            errs++;
            $display("FAIL %s ram: %0d words differ, first at %0d got %h expected %h",
                     tag, bad, first, ram[first], mram[first]);
        end
    endtask

    // ab: cycle number (after the start edge) in which abort is held high, 0 = none
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d,
                            input int n, input int ab, input bit noise,
                            input int tail, input int exp_cnt,
                            input int exp_dn, input string tag);
        logic [DW-1:0] dq [$];
        logic [31:0]   sa, da, ea;
        logic [DW-1:0] ed, gd;
        logic [79:0]   g, e;
        int nwr, act, last, dones, k;
        bit wr, on;
        nwr = (ab == 0) ? n : ((ab % 2 == 1) ? (ab - 1) / 2 : ab / 2);
        act = (ab == 0) ? 2 * n : ab;
        for (int i = 0; i < nwr; i++) begin
            sa = s + 32'(i);
            da = d + 32'(i);
            dq.push_back(mram[sa[AW-1:0]]);
            mram[da[AW-1:0]] = dq[i];
        end
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = n[AW:0];
        last  = 2 * n + 1 + tail;
        dones = 0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = (c == ab);
            if (noise && ((((c == 1) || (c == 2)) && c <= act) ||
                          (c == 2 * n + 1 && ab == 0))) begin
                start    = 1'b1;
                src_addr = $urandom;
                dst_addr = $urandom;
                len      = AW'($urandom) + 1'b1;
            end
            on = (c <= act) && (c <= 2 * n);
            wr = on && (c % 2 == 0);
            k  = (c - 1) / 2;
            ea = on ? (wr ? d + 32'(k) : s + 32'(k)) : 32'd0;
            ed = wr ? dq[k] : '0;
            gd = (on && !wr) ? '0 : bus.data_wr;
            e = {10'd0, on, (ab == 0 && c == 2 * n + 1), on, wr, ea, ed};
            g = {10'd0, busy, done, bus.mem_en, bus.mem_wr, bus.addr, gd};
            dones += int'(done);
            chk($sformatf("%s cyc%0d", tag, c), g, e);
        end
        abort = 1'b0;
        chk({tag, " count"}, 80'(count), 80'(exp_cnt));
        chk({tag, " done_pulses"}, 80'(dones), 80'(exp_dn));
        chk_ram(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            ram[i]  = $urandom;
            mram[i] = ram[i];
        end
        for (int i = 0; i < 4; i++) begin
            ram[i]  = 32'hA0A0_0000 + 32'(i);
            mram[i] = ram[i];
        end
        tbl[0] = '{32'd0,    32'd16,      4,    0, 1'b0, 2, 4,    1, "basic"};
        tbl[1] = '{32'd5,    32'd9,       0,    0, 1'b0, 2, 0,    1, "zero_len"};
        tbl[2] = '{32'd1022, 32'h405,     4,    0, 1'b0, 1, 4,    1, "wrap"};
        tbl[3] = '{32'd40,   32'd200,     8,    6, 1'b0, 3, 3,    0, "abort_wr"};
        tbl[4] = '{32'd300,  32'd301,     1,    0, 1'b0, 1, 1,    1, "after_abort"};
        tbl[5] = '{32'd10,   32'd900,     4,    3, 1'b0, 2, 1,    0, "abort_rd"};
        tbl[6] = '{32'd500,  32'd600,     3,    0, 1'b1, 0, 3,    1, "start_busy"};
        tbl[7] = '{32'd600,  32'd700,     2,    0, 1'b0, 2, 2,    1, "back2back"};
        tbl[8] = '{32'd100,  32'd101,     5,    0, 1'b0, 1, 5,    1, "overlap"};
        tbl[9] = '{32'd0,    32'd512,  1024,    0, 1'b0, 1, 1024, 1, "full"};

        #3;
        chk("reset_outputs",
            {10'd0, busy, done, bus.mem_en, bus.mem_wr, bus.addr, bus.data_wr},
            80'd0);
        chk("reset_count", 80'(count), 80'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_after_reset",
            {10'd0, busy, done, bus.mem_en, bus.mem_wr, bus.addr, bus.data_wr},
            80'd0);

        for (int i = 0; i < 10; i++)
            run_xfer(tbl[i].src, tbl[i].dst, tbl[i].n, tbl[i].ab,
                     tbl[i].noise, tbl[i].tail, tbl[i].cnt, tbl[i].dn,
                     tbl[i].tag);

        // reset in the second WRITE: only word 0 has landed
        @(negedge clk);
        start    = 1'b1;
        src_addr = 32'd60;
        dst_addr = 32'd800;
        len      = 11'd5;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("rst_pre_write", 80'(bus.mem_wr), 80'd1);
        #3 rstn = 1'b0;
        #1;
        chk("rst_async",
            {busy, done, count, bus.mem_en, bus.mem_wr, bus.addr, bus.data_wr},
            80'd0);
        mram[800] = mram[60];
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_idle",
            {10'd0, busy, done, bus.mem_en, bus.mem_wr, bus.addr, bus.data_wr},
            80'd0);
        chk_ram("rst_mid");
        run_xfer(32'd70, 32'd810, 3, 0, 1'b0, 1, 3, 1, "after_rst");

        for (int r = 0; r < 25; r++) begin
            logic [31:0] s, d;
            int n, ab, cnt;
            bit nz;
            s  = $urandom;
            d  = $urandom;
            n  = $urandom_range(0, 24);
            ab = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * n) : 0;
            nz = (n > 0) && ($urandom_range(0, 1) == 1);
            cnt = (ab == 0) ? n : ab / 2;
            run_xfer(s, d, n, ab, nz, 1, cnt, (ab == 0) ? 1 : 0,
                     $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/mem_copy_dma.md
# mem_copy_dma

Word-copy DMA engine that initiates transactions on the testbench/SoC single-cycle memory bus (mem_en, mem_wr, addr, data_rd, data_wr). It is the bus-initiator counterpart to the synchronous-write, combinational-read RAM model. On a start command, it copies len consecutive words from a source address to a destination address as a strict read-then-write sequence. It reports progress and completion to a controlling testbench or CPU-side register block.

## Interface
- AWIDTH, 10: RAM word-address width; sets the maximum transfer length of 2^AWIDTH words.
- DWIDTH, 32: data word width.

Ports (reset rstn, asynchronous, active-low; clock clk):
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- abort  in  1  synchronous cancel; sampled in READ/WRITE.
- src_addr  in  32  first source word address; latched on accepted start.
- dst_addr  in  32  first destination word address; latched on accepted start.
- len  in  AWIDTH+1  number of words to copy; latched on accepted start.
- busy  out  1  high in READ and WRITE.
- done  out  1  one-cycle completion pulse.
- count  out  AWIDTH+1  words fully written in the current or last transfer.
- mem_en  out  1  bus enable.
- mem_wr  out  1  bus write strobe.
- addr  out  32  bus word address.
- data_wr  out  DWIDTH  bus write data.
- data_rd  in  DWIDTH  bus read data; valid in the same cycle as mem_en=1, mem_wr=0.

## Operation
- FSM states: IDLE, READ, WRITE, DONE. Bus outputs and busy/done are Moore-decoded from state and registers only.
- IDLE:
  - Bus outputs: mem_en=0, mem_wr=0, addr=0, data_wr=0.
  - start=1 and len!=0: latch src_ptr, dst_ptr and remaining=len; clear count; go to READ.
  - start=1 and len=0: clear count; go to DONE with no bus activity.
- READ:
  - Bus outputs: mem_en=1, mem_wr=0, addr=src_ptr.
  - At the clock edge, capture data_rd into buf and go to WRITE.
- WRITE:
  - Bus outputs: mem_en=1, mem_wr=1, addr=dst_ptr, data_wr=buf.
  - At the clock edge: src_ptr+=1, dst_ptr+=1, remaining-=1, count+=1.
  - Next state is DONE if remaining was 1, else READ.
- DONE: done=1, bus idle; go to IDLE.
- start is ignored outside IDLE, including during DONE.
- abort=1 in READ or WRITE: go to IDLE at the next edge.
  - No done pulse is issued.
  - The bus cycle presented during that cycle still takes effect, so a write in progress completes and is counted.
  - count holds its value thereafter.
- Pointer arithmetic: 32-bit modulo 2^32. The RAM decodes addr[AWIDTH-1:0], so copies wrap around the array naturally.
- Overlapping regions use a forward copy, one word at a time. With dst=src+1, the first word is replicated across the destination; this is defined behaviour.
- count holds after done until the next accepted start.
- Reset (asynchronous) forces IDLE mid-transfer. Reset values:
  - Outputs: busy=0, done=0, count=0, mem_en=0, mem_wr=0, addr=0, data_wr=0.
  - Internal: buf=0, pointers=0, remaining=0.

## Timing
- Cycle 0: start is sampled high at the end of the cycle.
- Cycle 2k+1: READ of word k. Cycle 2k+2: WRITE of word k. This holds for k=0..len-1.
- Cycle 2·len+1: DONE, with done=1.
- Cycle 2·len+2: IDLE; a new start can be sampled in this cycle.
- Throughput: 2 cycles per word. Full-size transfer of 2^AWIDTH words takes 2^(AWIDTH+1)+1 cycles to done.
- len=0: done=1 in cycle 1; mem_en stays 0 throughout.
- busy falls in the DONE cycle. busy and done are never high together.
- Abort sampled in cycle c: IDLE from cycle c+1; busy=0 in c+1.

## Test plan
- Basic copy:
  - Stimulus: RAM[0..3]=A0,A1,A2,A3; start with src=0, dst=16, len=4.
  - Required: RAM[16..19]=A0..A3; done pulses exactly once, 9 cycles after the start edge; count=4; 4 writes and 4 reads on the bus, strictly alternating.
- Zero length:
  - Stimulus: len=0.
  - Required: done in cycle 1; mem_en never asserted; count=0; no RAM word changes.
- Wrap-around (AWIDTH=10):
  - Stimulus: src=1022, dst=0x400+5, len=4.
  - Required: reads at addr 1022,1023,1024,1025 hit RAM[1022],RAM[1023],RAM[0],RAM[1]; these land in RAM[5..8].
- Abort:
  - Stimulus: len=8, abort asserted during the third WRITE cycle.
  - Required: exactly 3 destination words written; count=3; no done pulse; busy low the next cycle; a following start with len=1 completes normally.
- Start while busy, and back-to-back:
  - Stimulus: start pulses during READ, WRITE and DONE.
  - Required: all ignored; the latched parameters are unchanged; a start in the first IDLE cycle after DONE is accepted.
- Reset mid-transfer:
  - Stimulus: rstn low during WRITE.
  - Required: all outputs 0 immediately (asynchronously); FSM in IDLE after release; the next transfer is correct.
